dds_phase_gen: RTL and testbench

DDS phase accumulator and sine-sample generator, the consumer of the 64-bit frequency control word produced by the frequency controller. It latches the tuning word and accumulates phase in a phase-continuous way. It folds the phase into a quarter-wave address for an external synchronous sine ROM and rebuilds the full signed waveform as offset-binary DAC codes. It sits between the frequency controller and the DAC output register.

---
 rtl/dds_phase_gen_if.sv | 40 ++++
 rtl/dds_phase_gen.sv | 128 ++++++++++++
 tb/tb_dds_phase_gen.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_phase_gen_if.sv
// -----------------------------------------------------------------------------
// dds_phase_gen_if
// Bundles the tuning/control inputs, the external quarter-wave ROM port and the
// DAC sample outputs of the DDS phase generator.
//   freq_c/freq_load : tuning word and its one-cycle load strobe
//   phase_off        : 16-bit phase offset applied to the top of the accumulator
//   enable/ph_clr    : accumulate enable and synchronous accumulator clear
//   rom_addr         : quarter-wave ROM address (DDS -> ROM)
//   rom_data         : unsigned ROM magnitude, one cycle after rom_addr (ROM -> DDS)
//   dac_data         : offset-binary DAC sample
//   dac_valid        : sample belongs to an enabled accumulator cycle
//   wrap             : accumulator carry-out pulse
// master = controller/ROM side, slave = dds_phase_gen.
// -----------------------------------------------------------------------------
interface dds_phase_gen_if #(
    parameter int PHASE_W = 64,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 14
);
    logic [PHASE_W-1:0] freq_c;
    logic               freq_load;
    logic [15:0]        phase_off;
    logic               enable;
    logic               ph_clr;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-2:0]  rom_data;
    logic [DATA_W-1:0]  dac_data;
    logic               dac_valid;
    logic               wrap;

    modport master (
        output freq_c, freq_load, phase_off, enable, ph_clr, rom_data,
        input  rom_addr, dac_data, dac_valid, wrap
    );

    modport slave (
        input  freq_c, freq_load, phase_off, enable, ph_clr, rom_data,
        output rom_addr, dac_data, dac_valid, wrap
    );
endinterface

// File: rtl/dds_phase_gen.sv
// -----------------------------------------------------------------------------
// dds_phase_gen
// Phase accumulator plus quarter-wave sine reconstruction. The tuning word is
// latched on freq_load without touching the accumulator, so frequency changes
// are phase-continuous. The top 16 accumulator bits plus phase_off are folded
// into a quarter-wave ROM address; the ROM magnitude is then mirrored about
// mid-scale to rebuild the full wave as offset-binary DAC codes.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : dds_phase_gen_if.slave (control inputs, ROM port, DAC outputs)
// Latency: accumulate edge N -> rom_addr at N+1 -> rom_data at N+2 ->
//          dac_data/dac_valid at N+3.
// -----------------------------------------------------------------------------
module dds_phase_gen #(
    parameter int                 PHASE_W = 64,
    parameter int                 ADDR_W  = 12,
    parameter int                 DATA_W  = 14,
    parameter logic [PHASE_W-1:0] FCW_RST = PHASE_W'(64'd153722867281)
) (
    input logic            clk,
    input logic            rst,
    dds_phase_gen_if.slave bus
);

    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    // Quadrants 1 and 3 run the quarter wave backwards, so the index is mirrored.
    function automatic logic [ADDR_W-1:0] fold_addr(input logic odd_quad,
                                                    input logic [ADDR_W-1:0] idx);
        return odd_quad ? ~idx : idx;
    endfunction

    // Lower half-wave (quadrants 2,3) is the negated magnitude; adding the
    // signed value to mid-scale yields offset binary. |mag| <= MID-1 keeps the
    // result within 1..2*MID-1, so no saturation is required.
    function automatic logic [DATA_W-1:0] to_offset_binary(input logic [1:0] quad,
                                                           input logic [DATA_W-2:0] mag);
        logic signed [DATA_W-1:0] smp;
        smp = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        return MID + $unsigned(smp);
    endfunction

    logic [PHASE_W-1:0] fcw_q, fcw_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               wrap_q, wrap_d;
    logic               vld_p0_q, vld_p0_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [1:0]         quad_p1_q, quad_p1_d;
    logic               vld_p1_q, vld_p1_d;
    logic [1:0]         quad_p2_q, quad_p2_d;
    logic               vld_p2_q, vld_p2_d;
    logic [DATA_W-1:0]  dac_data_q, dac_data_d;
    logic               dac_valid_q, dac_valid_d;

    logic [PHASE_W:0]   sum_c;
    logic [1:0]         quad_c;
    logic [ADDR_W-1:0]  idx_c;
    logic [1:0]         phase_unused;

    always_comb begin
        fcw_d        = fcw_q;
        acc_d        = acc_q;
        wrap_d       = 1'b0;
        sum_c        = {1'b0, acc_q} + {1'b0, fcw_q};

        // Stage 0: tuning register and accumulator. A load in the same cycle
        // as an accumulate only affects the following accumulation.
        if (bus.freq_load) begin
            fcw_d = bus.freq_c;
        end
        if (bus.ph_clr) begin
            acc_d = '0;
        end else if (bus.enable) begin
            acc_d  = sum_c[PHASE_W-1:0];
            wrap_d = sum_c[PHASE_W];
        end
        vld_p0_d     = bus.enable;

        // Stage 1: phase offset and quarter-wave fold.
        {quad_c, idx_c, phase_unused} = acc_q[PHASE_W-1 -: 16] + bus.phase_off;
        rom_addr_d   = fold_addr(quad_c[0], idx_c);
        quad_p1_d    = quad_c;
        vld_p1_d     = vld_p0_q;

        // Stage 2: external ROM read in flight.
        quad_p2_d    = quad_p1_q;
        vld_p2_d     = vld_p1_q;

        // Stage 3: rebuild the signed sample as offset binary.
        dac_data_d   = to_offset_binary(quad_p2_q, bus.rom_data);
        dac_valid_d  = vld_p2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcw_q       <= FCW_RST;
            acc_q       <= '0;
            wrap_q      <= 1'b0;
            vld_p0_q    <= 1'b0;
            rom_addr_q  <= '0;
            quad_p1_q   <= '0;
            vld_p1_q    <= 1'b0;
            quad_p2_q   <= '0;
            vld_p2_q    <= 1'b0;
            dac_data_q  <= MID;
            dac_valid_q <= 1'b0;
        end else begin
            fcw_q       <= fcw_d;
            acc_q       <= acc_d;
            wrap_q      <= wrap_d;
            vld_p0_q    <= vld_p0_d;
            rom_addr_q  <= rom_addr_d;
            quad_p1_q   <= quad_p1_d;
            vld_p1_q    <= vld_p1_d;
            quad_p2_q   <= quad_p2_d;
            vld_p2_q    <= vld_p2_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.dac_data  = dac_data_q;
    assign bus.dac_valid = dac_valid_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_gen
// Bench for dds_phase_gen with a registered quarter-wave ROM stand-in and a
// history-based reference model: every accumulator value, enable and
// phase_off seen at each clock edge is recorded, and expected outputs are
// derived from the record a fixed number of edges back.
// -----------------------------------------------------------------------------
module tb_dds_phase_gen;
    localparam int          PHASE_W = 64;
    localparam int          ADDR_W  = 12;
    localparam int          DATA_W  = 14;
    localparam logic [63:0] FCW_DEF = 64'd153722867281;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dds_phase_gen_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dds_phase_gen #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM stand-in: registered address, content selected by rom_mode
    // (mode 0: magnitude = address, mode 1: scrambled magnitude).
    logic [ADDR_W-1:0] rom_addr_r = '0;
    bit                rom_mode   = 1'b0;
    always @(posedge clk) rom_addr_r <= bus.rom_addr;
    assign bus.rom_data = rom_mode ? ({1'b0, rom_addr_r} ^ 13'h1A5A) : {1'b0, rom_addr_r};

    int checks = 0;
    int errors = 0;

    // Reference model state: history of accumulator values / inputs per edge.
    logic [63:0] m_fcw;
    logic [63:0] h_acc[$];
    bit          h_en[$];
    logic [15:0] h_po[$];

    logic [63:0] exp_acc;
    logic        exp_wrap;
    logic [11:0] exp_addr;
    logic        exp_valid;
    logic [13:0] exp_dac;
    bit          dac_known;

    function automatic logic [12:0] rom_val(input logic [11:0] a);
        return rom_mode ? ({1'b0, a} ^ 13'h1A5A) : {1'b0, a};
    endfunction

    function automatic logic [11:0] ref_addr(input logic [63:0] acc, input logic [15:0] po);
        int ph, quad, idx;
        ph   = (int'(acc[63:48]) + int'(po)) % 65536;
        quad = ph / 16384;
        idx  = (ph % 16384) / 4;
        if (quad % 2 == 1) return 12'(4095 - idx);
        return 12'(idx);
    endfunction

    function automatic logic [13:0] ref_sample(input logic [63:0] acc, input logic [15:0] po);
        int ph, mag;
        ph  = (int'(acc[63:48]) + int'(po)) % 65536;
        mag = int'(rom_val(ref_addr(acc, po)));
        if (ph < 32768) return 14'(8192 + mag);
        return 14'(8192 - mag);
    endfunction

    task automatic reset_model();
        h_acc.delete(); h_en.delete(); h_po.delete();
        h_acc.push_back(64'd0); h_en.push_back(1'b0); h_po.push_back(16'd0);
        m_fcw = FCW_DEF;
    endtask

    // Advance model and DUT by one clock edge; fills exp_* for the caller.
    task automatic step();
        logic [64:0] sum;
        logic [63:0] prev, nxt;
        logic        w;
        int          t;
        prev = h_acc[h_acc.size()-1];
        nxt  = prev;
        w    = 1'b0;
        if (bus.ph_clr) begin
            nxt = 64'd0;
        end else if (bus.enable) begin
            sum = {1'b0, prev} + {1'b0, m_fcw};
            nxt = sum[63:0];
            w   = sum[64];
        end
        if (bus.freq_load) m_fcw = bus.freq_c;
        h_acc.push_back(nxt); h_en.push_back(bus.enable); h_po.push_back(bus.phase_off);
        @(posedge clk); #1;
        t         = h_acc.size() - 1;
        exp_acc   = nxt;
        exp_wrap  = w;
        exp_addr  = ref_addr(h_acc[t-1], h_po[t]);
        exp_valid = (t >= 3) ? h_en[t-3] : 1'b0;
        dac_known = (t >= 3);
        exp_dac   = dac_known ? ref_sample(h_acc[t-3], h_po[t-2]) : 14'd8192;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #12;
        checks++; if (bus.rom_addr !== 12'd0) begin errors++; $display("FAIL por_rom_addr got %0d expected 0", bus.rom_addr); end
        checks++; if (bus.dac_data !== 14'd8192) begin errors++; $display("FAIL por_dac_data got %0d expected 8192", bus.dac_data); end
        checks++; if (bus.dac_valid !== 1'b0) begin errors++; $display("FAIL por_dac_valid got %b expected 0", bus.dac_valid); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL por_wrap got %b expected 0", bus.wrap); end
        @(negedge clk) rst = 1'b1;
        reset_model();
        bus.enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++; if (dut.acc_q !== 64'(k) * FCW_DEF) begin errors++; $display("FAIL default_fcw_acc k=%0d got %0d expected %0d", k, dut.acc_q, 64'(k) * FCW_DEF); end
            checks++; if (bus.dac_valid !== exp_valid) begin errors++; $display("FAIL default_fcw_valid k=%0d got %b expected %b", k, bus.dac_valid, exp_valid); end
        end
        // Make wrap pulse every cycle, then reset in the middle of a cycle.
        bus.freq_load = 1'b1; bus.freq_c = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        bus.freq_load = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checks++; if (bus.wrap !== 1'b1) begin errors++; $display("FAIL pre_reset_wrap got %b expected 1", bus.wrap); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.rom_addr !== 12'd0) begin errors++; $display("FAIL async_rom_addr got %0d expected 0", bus.rom_addr); end
        checks++; if (bus.dac_data !== 14'd8192) begin errors++; $display("FAIL async_dac_data got %0d expected 8192", bus.dac_data); end
        checks++; if (bus.dac_valid !== 1'b0) begin errors++; $display("FAIL async_dac_valid got %b expected 0", bus.dac_valid); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL async_wrap got %b expected 0", bus.wrap); end
        checks++; if (dut.acc_q !== 64'd0) begin errors++; $display("FAIL async_acc got %0d expected 0", dut.acc_q); end
        @(negedge clk) rst = 1'b1;
        reset_model();
        step();
        checks++; if (dut.acc_q !== FCW_DEF) begin errors++; $display("FAIL fcw_restored got %0d expected %0d", dut.acc_q, FCW_DEF); end
    endtask

    task automatic test_quarter_turn(input logic [15:0] po);
        logic [13:0] dac_tab  [4] = '{14'd8192, 14'd12287, 14'd8192, 14'd4097};
        logic [11:0] addr_tab [4] = '{12'd0, 12'd4095, 12'd0, 12'd4095};
        logic        ew;
        int          qo;
        int          nwrap;
        qo = int'(po[15:14]);
        nwrap = 0;
        rom_mode = 1'b0;
        bus.phase_off = po; bus.ph_clr = 1'b1; bus.enable = 1'b1;
        bus.freq_load = 1'b1; bus.freq_c = 64'h4000_0000_0000_0000;
        step();
        bus.ph_clr = 1'b0; bus.freq_load = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            step();
            ew = (j % 4 == 0);
            if (bus.wrap === 1'b1) nwrap++;
            checks++; if (bus.wrap !== ew) begin errors++; $display("FAIL quarter_wrap po=%h j=%0d got %b expected %b", po, j, bus.wrap, ew); end
            checks++; if (bus.rom_addr !== addr_tab[(j - 1 + qo) % 4]) begin errors++; $display("FAIL quarter_rom_addr po=%h j=%0d got %0d expected %0d", po, j, bus.rom_addr, addr_tab[(j - 1 + qo) % 4]); end
            if (j >= 3) begin
                checks++; if (bus.dac_data !== dac_tab[(j - 3 + qo) % 4]) begin errors++; $display("FAIL quarter_dac po=%h j=%0d got %0d expected %0d", po, j, bus.dac_data, dac_tab[(j - 3 + qo) % 4]); end
            end
            checks++; if (bus.dac_valid !== exp_valid) begin errors++; $display("FAIL quarter_valid po=%h j=%0d got %b expected %b", po, j, bus.dac_valid, exp_valid); end
        end
        checks++; if (nwrap !== 4) begin errors++; $display("FAIL quarter_wrap_count po=%h got %0d expected 4", po, nwrap); end
    endtask

    task automatic test_load_continuity();
        bus.phase_off = 16'h0; bus.ph_clr = 1'b1; bus.enable = 1'b1;
        bus.freq_load = 1'b1; bus.freq_c = 64'd1 << 60;
        step();
        bus.ph_clr = 1'b0; bus.freq_load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++; if (dut.acc_q !== (64'(k) << 60)) begin errors++; $display("FAIL load_acc k=%0d got %h expected %h", k, dut.acc_q, 64'(k) << 60); end
        end
        bus.freq_load = 1'b1; bus.freq_c = 64'd1 << 61;
        step();
        checks++; if (dut.acc_q !== (64'd6 << 60)) begin errors++; $display("FAIL load_same_cycle got %h expected %h", dut.acc_q, 64'd6 << 60); end
        bus.freq_load = 1'b0;
        step();
        checks++; if (dut.acc_q !== (64'd8 << 60)) begin errors++; $display("FAIL load_new_fcw got %h expected %h", dut.acc_q, 64'd8 << 60); end
        checks++; if (bus.rom_addr !== exp_addr) begin errors++; $display("FAIL load_rom_addr got %0d expected %0d", bus.rom_addr, exp_addr); end
        step();
        checks++; if (dut.acc_q !== (64'd10 << 60)) begin errors++; $display("FAIL load_next got %h expected %h", dut.acc_q, 64'd10 << 60); end
    endtask

    task automatic test_hold_clear();
        logic ev;
        bus.enable = 1'b0;
        for (int s = 1; s <= 6; s++) begin
            step();
            ev = (s <= 3);
            checks++; if (dut.acc_q !== (64'd10 << 60)) begin errors++; $display("FAIL hold_acc s=%0d got %h expected %h", s, dut.acc_q, 64'd10 << 60); end
            checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap s=%0d got %b expected 0", s, bus.wrap); end
            checks++; if (bus.dac_valid !== ev) begin errors++; $display("FAIL hold_valid s=%0d got %b expected %b", s, bus.dac_valid, ev); end
        end
        checks++; if (bus.dac_data !== exp_dac) begin errors++; $display("FAIL hold_dac got %0d expected %0d", bus.dac_data, exp_dac); end
        bus.ph_clr = 1'b1; bus.enable = 1'b1;
        step();
        checks++; if (dut.acc_q !== 64'd0) begin errors++; $display("FAIL clear_acc got %h expected 0", dut.acc_q); end
        bus.ph_clr = 1'b0;
        step(); step(); step();
        checks++; if (bus.dac_data !== 14'd8192) begin errors++; $display("FAIL clear_dac got %0d expected 8192", bus.dac_data); end
        checks++; if (bus.dac_valid !== 1'b1) begin errors++; $display("FAIL clear_valid got %b expected 1", bus.dac_valid); end
    endtask

    task automatic test_wrap_edge();
        logic ew;
        bus.ph_clr = 1'b1; bus.enable = 1'b1;
        bus.freq_load = 1'b1; bus.freq_c = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        bus.ph_clr = 1'b0; bus.freq_load = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step();
            ew = (j > 1);
            checks++; if (dut.acc_q !== 64'd0 - 64'(j)) begin errors++; $display("FAIL wrap_edge_acc j=%0d got %h expected %h", j, dut.acc_q, 64'd0 - 64'(j)); end
            checks++; if (bus.wrap !== ew) begin errors++; $display("FAIL wrap_edge_wrap j=%0d got %b expected %b", j, bus.wrap, ew); end
        end
    endtask

    task automatic test_random();
        rom_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bus.freq_load = ($urandom_range(0, 7) == 0);
            bus.freq_c    = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) bus.freq_c = bus.freq_c >> $urandom_range(0, 40);
            bus.enable    = ($urandom_range(0, 3) != 0);
            bus.ph_clr    = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 9) == 0) bus.phase_off = 16'($urandom);
            step();
            checks++; if (dut.acc_q !== exp_acc) begin errors++; $display("FAIL rand_acc i=%0d got %h expected %h", i, dut.acc_q, exp_acc); end
            checks++; if (bus.wrap !== exp_wrap) begin errors++; $display("FAIL rand_wrap i=%0d got %b expected %b", i, bus.wrap, exp_wrap); end
            checks++; if (bus.rom_addr !== exp_addr) begin errors++; $display("FAIL rand_rom_addr i=%0d got %0d expected %0d", i, bus.rom_addr, exp_addr); end
            checks++; if (bus.dac_valid !== exp_valid) begin errors++; $display("FAIL rand_valid i=%0d got %b expected %b", i, bus.dac_valid, exp_valid); end
            if (dac_known) begin
                checks++; if (bus.dac_data !== exp_dac) begin errors++; $display("FAIL rand_dac i=%0d got %0d expected %0d", i, bus.dac_data, exp_dac); end
            end
        end
        bus.freq_load = 1'b0; bus.ph_clr = 1'b0; bus.enable = 1'b0;
    endtask

    initial begin
        bus.freq_c = '0; bus.freq_load = 1'b0; bus.phase_off = '0;
        bus.enable = 1'b0; bus.ph_clr = 1'b0;
        reset_model();
        test_reset();
        test_quarter_turn(16'h0000);
        test_quarter_turn(16'h4000);
        test_load_continuity();
        test_hold_clear();
        test_wrap_edge();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
